// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle MIPS control FSM (slave side) and the datapath/bench (master side).
`timescale 1ns/1ps
interface mc_ctrl_if #(parameter int unsigned CNT_W = 32);
    logic [5:0]       OpCode;
    logic [5:0]       funct;
    logic             Zero;
    logic             PcEn;
    logic [1:0]       PCSource;
    logic             IorD;
    logic             MemR;
    logic             MemW;
    logic             IRWrite;
    logic             RegDst;
    logic             Mem2R;
    logic             RegW;
    logic             AluSrcA;
    logic [1:0]       AluSrcB;
    logic [1:0]       ExtOp;
    logic [4:0]       Aluctrl;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCnt;
    logic             Illegal;

    modport master (
        output OpCode, funct, Zero,
        input  PcEn, PCSource, IorD, MemR, MemW, IRWrite, RegDst, Mem2R, RegW,
               AluSrcA, AluSrcB, ExtOp, Aluctrl, State, InstrCnt, Illegal
    );
    modport slave (
        input  OpCode, funct, Zero,
        output PcEn, PCSource, IorD, MemR, MemW, IRWrite, RegDst, Mem2R, RegW,
               AluSrcA, AluSrcB, ExtOp, Aluctrl, State, InstrCnt, Illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with retired-instruction counter.
// Optional: define MC_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes/functs instead of treating them as NOPs.
`timescale 1ns/1ps
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    mc_ctrl_if.slave    bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_RWB   = 4'd7,
        S_EXEC_I = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_XOR = 5'd7;
    localparam logic [4:0] ALU_NOR = 5'd8, ALU_LUI = 5'd9;

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d, fn_q, fn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Where an illegal instruction goes: trap state, or straight back to FETCH as a NOP.
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_e S_ILLEGAL = S_TRAP;
`else
    localparam state_e S_ILLEGAL = S_FETCH;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        fn_d         = fn_q;
        bus.PcEn     = 1'b0;
        bus.PCSource = 2'd0;
        bus.IorD     = 1'b0;
        bus.MemR     = 1'b0;
        bus.MemW     = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.Mem2R    = 1'b0;
        bus.RegW     = 1'b0;
        bus.AluSrcA  = 1'b0;
        bus.AluSrcB  = 2'd0;
        bus.ExtOp    = 2'd0;
        bus.Aluctrl  = ALU_ADD;
        bus.Illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.MemR    = 1'b1;
                bus.IRWrite = 1'b1;
                bus.AluSrcB = 2'd1;
                bus.PcEn    = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                op_d        = bus.OpCode;
                fn_d        = bus.funct;
                bus.AluSrcB = 2'd3;
                bus.ExtOp   = 2'd1;
                case (bus.OpCode)
                    OP_LW, OP_SW:                    state_d = S_MEMADR;
                    OP_RTYPE:                        state_d = S_EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_ANDI,
                    OP_ORI, OP_SLTI, OP_LUI:         state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
                    OP_J:                            state_d = S_JUMP;
                    default:                         state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = 2'd2;
                bus.ExtOp   = 2'd1;
                state_d     = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemR = 1'b1;
                bus.IorD = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegW  = 1'b1;
                bus.Mem2R = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemW = 1'b1;
                bus.IorD = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC_R: begin
                bus.AluSrcA = 1'b1;
                state_d     = S_RWB;
                case (fn_q)
                    6'h20, 6'h21: bus.Aluctrl = ALU_ADD;
                    6'h22, 6'h23: bus.Aluctrl = ALU_SUB;
                    6'h24:        bus.Aluctrl = ALU_AND;
                    6'h25:        bus.Aluctrl = ALU_OR;
                    6'h26:        bus.Aluctrl = ALU_XOR;
                    6'h27:        bus.Aluctrl = ALU_NOR;
                    6'h2A:        bus.Aluctrl = ALU_SLT;
                    6'h00:        bus.Aluctrl = ALU_SLL;
                    6'h02:        bus.Aluctrl = ALU_SRL;
                    default:      state_d     = S_ILLEGAL;
                endcase
            end
            S_RWB: begin
                bus.RegW   = 1'b1;
                bus.RegDst = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                bus.AluSrcA = 1'b1;
                bus.AluSrcB = 2'd2;
                state_d     = S_IWB;
                case (op_q)
                    OP_ADDI, OP_ADDIU: begin bus.ExtOp = 2'd1; bus.Aluctrl = ALU_ADD; end
                    OP_SLTI:           begin bus.ExtOp = 2'd1; bus.Aluctrl = ALU_SLT; end
                    OP_ANDI:           begin bus.ExtOp = 2'd0; bus.Aluctrl = ALU_AND; end
                    OP_ORI:            begin bus.ExtOp = 2'd0; bus.Aluctrl = ALU_OR;  end
                    OP_LUI:            begin bus.ExtOp = 2'd2; bus.Aluctrl = ALU_LUI; end
                    default:           ;
                endcase
            end
            S_IWB: begin
                bus.RegW = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                bus.AluSrcA  = 1'b1;
                bus.Aluctrl  = ALU_SUB;
                bus.PCSource = 2'd1;
                bus.PcEn     = (op_q == OP_BNE) ? ~bus.Zero : bus.Zero;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSource = 2'd2;
                bus.PcEn     = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                bus.Illegal = 1'b1;
`endif
                state_d     = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase

        // A write-enable must never fire during the reset cycle, even mid-instruction.
        if (Reset) begin
            bus.PcEn    = 1'b0;
            bus.IRWrite = 1'b0;
            bus.MemW    = 1'b0;
            bus.RegW    = 1'b0;
        end

        cnt_d = cnt_q;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign bus.State    = state_q;
    assign bus.InstrCnt = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected controls queued with stimulus, compared each cycle.
`timescale 1ns/1ps
module tb_mc_ctrl;
    localparam int unsigned CNT_W = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    mc_ctrl_if #(.CNT_W(CNT_W)) bus ();
    mc_ctrl #(.CNT_W(CNT_W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]       st;
        logic             pcen;
        logic [1:0]       pcsrc;
        logic             iord, memr, memw, irw, regdst, mem2r, regw, srca;
        logic [1:0]       srcb, extop;
        logic [4:0]       aluc;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] op, fn;
        logic       z;
        exp_t       e;
    } ent_t;

    ent_t             sbq[$];
    logic [CNT_W-1:0] exp_cnt;
    int               checks;
    int               errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic r_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
    endfunction

    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 5'd0;
            6'h22, 6'h23: return 5'd1;
            6'h24:        return 5'd2;
            6'h25:        return 5'd3;
            6'h26:        return 5'd7;
            6'h27:        return 5'd8;
            6'h2A:        return 5'd4;
            6'h00:        return 5'd5;
            6'h02:        return 5'd6;
            default:      return 5'd0;
        endcase
    endfunction

    function automatic exp_t exp_for(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input logic [3:0] st);
        exp_t e = '0;
        e.st  = st;
        e.cnt = exp_cnt;
        case (st)
            4'd0:  begin e.memr = 1; e.irw = 1; e.srcb = 2'd1; e.pcen = 1; end
            4'd1:  begin e.srcb = 2'd3; e.extop = 2'd1; end
            4'd2:  begin e.srca = 1; e.srcb = 2'd2; e.extop = 2'd1; end
            4'd3:  begin e.memr = 1; e.iord = 1; end
            4'd4:  begin e.regw = 1; e.mem2r = 1; end
            4'd5:  begin e.memw = 1; e.iord = 1; end
            4'd6:  begin e.srca = 1; e.aluc = r_alu(fn); end
            4'd7:  begin e.regw = 1; e.regdst = 1; end
            4'd8: begin
                e.srca = 1; e.srcb = 2'd2;
                case (op)
                    6'h08, 6'h09: begin e.extop = 2'd1; e.aluc = 5'd0; end
                    6'h0A:        begin e.extop = 2'd1; e.aluc = 5'd4; end
                    6'h0C:        begin e.extop = 2'd0; e.aluc = 5'd2; end
                    6'h0D:        begin e.extop = 2'd0; e.aluc = 5'd3; end
                    6'h0F:        begin e.extop = 2'd2; e.aluc = 5'd9; end
                    default:      ;
                endcase
            end
            4'd9:  e.regw = 1;
            4'd10: begin e.srca = 1; e.aluc = 5'd1; e.pcsrc = 2'd1; e.pcen = (op == 6'h05) ? !z : z; end
            4'd11: begin e.pcsrc = 2'd2; e.pcen = 1; end
            4'd12: e.ill = 1;
            default: ;
        endcase
        if (rst) begin e.pcen = 0; e.irw = 0; e.memw = 0; e.regw = 0; end
        return e;
    endfunction

    task automatic push_cycle(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic [3:0] st);
        ent_t t;
        t.rst = rst; t.op = op; t.fn = fn; t.z = z;
        t.e   = exp_for(rst, op, fn, z, st);
        sbq.push_back(t);
    endtask

    // Illegal instruction: trap for a while then reset, or retire as a NOP.
    task automatic push_illegal(input logic [5:0] op, input logic [5:0] fn);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) push_cycle(0, op, fn, 0, 4'd12);
        push_cycle(1, op, fn, 0, 4'd12);
        exp_cnt = '0;
`else
        exp_cnt++;
`endif
    endtask

    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        push_cycle(0, op, fn, z, 4'd0);
        push_cycle(0, op, fn, z, 4'd1);
        case (op)
            6'h23: begin push_cycle(0, op, fn, z, 4'd2); push_cycle(0, op, fn, z, 4'd3);
                         push_cycle(0, op, fn, z, 4'd4); exp_cnt++; end
            6'h2B: begin push_cycle(0, op, fn, z, 4'd2); push_cycle(0, op, fn, z, 4'd5); exp_cnt++; end
            6'h00: begin
                push_cycle(0, op, fn, z, 4'd6);
                if (r_ok(fn)) begin push_cycle(0, op, fn, z, 4'd7); exp_cnt++; end
                else push_illegal(op, fn);
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
                push_cycle(0, op, fn, z, 4'd8); push_cycle(0, op, fn, z, 4'd9); exp_cnt++;
            end
            6'h04, 6'h05: begin push_cycle(0, op, fn, z, 4'd10); exp_cnt++; end
            6'h02:        begin push_cycle(0, op, fn, z, 4'd11); exp_cnt++; end
            default:      push_illegal(op, fn);
        endcase
    endtask

    task automatic drain();
        ent_t t;
        exp_t o;
        int   n = 0;
        while (sbq.size() > 0) begin
            t = sbq.pop_front();
            @(negedge Clk);
            Reset      = t.rst;
            bus.OpCode = t.op;
            bus.funct  = t.fn;
            bus.Zero   = t.z;
            #1;
            o.st = bus.State;     o.pcen = bus.PcEn;     o.pcsrc = bus.PCSource;
            o.iord = bus.IorD;    o.memr = bus.MemR;     o.memw = bus.MemW;
            o.irw = bus.IRWrite;  o.regdst = bus.RegDst; o.mem2r = bus.Mem2R;
            o.regw = bus.RegW;    o.srca = bus.AluSrcA;  o.srcb = bus.AluSrcB;
            o.extop = bus.ExtOp;  o.aluc = bus.Aluctrl;  o.ill = bus.Illegal;
            o.cnt = bus.InstrCnt;
            check($sformatf("cyc%0d state op=%h", n, t.op), 32'(o.st), 32'(t.e.st));
            check($sformatf("cyc%0d ctrl st=%0d op=%h fn=%h", n, t.e.st, t.op, t.fn), 32'(o), 32'(t.e));
            n++;
        end
    endtask

    initial begin
        logic [5:0] rfn [11];
        logic [5:0] iop [6];
        rfn = '{6'h23, 6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
        iop = '{6'h0D, 6'h0F, 6'h08, 6'h09, 6'h0A, 6'h0C};
        checks = 0; errors = 0; exp_cnt = '0;
        bus.OpCode = '0; bus.funct = '0; bus.Zero = 1'b0;
        @(posedge Clk);

        push_cycle(1, 6'h00, 6'h00, 0, 4'd0);
        push_cycle(1, 6'h00, 6'h00, 0, 4'd0);
        push_instr(6'h23, 6'h00, 0);
        push_instr(6'h2B, 6'h00, 0);
        foreach (rfn[i]) push_instr(6'h00, rfn[i], 0);
        foreach (iop[i]) push_instr(iop[i], 6'h00, 0);
        push_instr(6'h04, 6'h00, 1);
        push_instr(6'h04, 6'h00, 0);
        push_instr(6'h05, 6'h00, 1);
        push_instr(6'h05, 6'h00, 0);
        push_instr(6'h02, 6'h00, 0);
        push_instr(6'h3F, 6'h00, 0);
        push_instr(6'h00, 6'h3F, 0);

        // Reset landing in a write-back cycle and in a store cycle.
        push_cycle(0, 6'h23, 6'h00, 0, 4'd0);
        push_cycle(0, 6'h23, 6'h00, 0, 4'd1);
        push_cycle(0, 6'h23, 6'h00, 0, 4'd2);
        push_cycle(0, 6'h23, 6'h00, 0, 4'd3);
        push_cycle(1, 6'h23, 6'h00, 0, 4'd4);
        exp_cnt = '0;
        push_instr(6'h02, 6'h00, 0);
        push_cycle(0, 6'h2B, 6'h00, 0, 4'd0);
        push_cycle(0, 6'h2B, 6'h00, 0, 4'd1);
        push_cycle(0, 6'h2B, 6'h00, 0, 4'd2);
        push_cycle(1, 6'h2B, 6'h00, 0, 4'd5);
        exp_cnt = '0;
        push_instr(6'h0D, 6'h00, 0);
        push_cycle(0, 6'h00, 6'h00, 0, 4'd0);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS datapath.
- Sequences a single shared ALU/memory path through the phases FETCH, DECODE, EXEC, MEM and WB, one phase per Clk.
- Drives PC, IR, GPR, DMem, ALU and Extender controls in place of the single-cycle combinational Ctrl.
- Keeps a retired-instruction counter for the seg7x16 debug display.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- OpCode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- PcEn  out  1  PC load enable.
- PCSource  out  2  PC mux select: 0=ALU result, 1=ALUOut register (branch target), 2=jump target.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemR  out  1  memory read.
- MemW  out  1  memory write.
- IRWrite  out  1  IR load.
- RegDst  out  1  write-register select: 0=rt, 1=rd.
- Mem2R  out  1  GPR write data select: 1=MDR, 0=ALUOut.
- RegW  out  1  GPR write.
- AluSrcA  out  1  ALU A select: 0=PC, 1=rs.
- AluSrcB  out  2  ALU B select: 0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2.
- ExtOp  out  2  extender mode: 0=zero, 1=sign, 2=lui (imm<<16).
- Aluctrl  out  5  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 XOR, 8 NOR, 9 LUI.
- State  out  4  current state, for debug.
- InstrCnt  out  CNT_W  retired-instruction count.
- Illegal  out  1  illegal-opcode flag.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10, JUMP=11, TRAP=12.
- Reset (sync): State=FETCH, InstrCnt=0, Illegal=0, latched op/funct=0.
  - While Reset=1, PcEn, IRWrite, MemW and RegW are forced to 0.
- Outputs are decoded from the state register and the latched op/funct (Moore). Every control not listed for a state is 0.
- FETCH: MemR=1, IorD=0, IRWrite=1, AluSrcA=0, AluSrcB=1, Aluctrl=ADD, PCSource=0, PcEn=1.
  - Next state: DECODE.
- DECODE:
  - Latch OpCode/funct internally; later states use only the latched copy.
  - AluSrcA=0, AluSrcB=3, ExtOp=1, Aluctrl=ADD (branch target into ALUOut).
  - Next state by opcode: lw(23h)/sw(2Bh)->MEMADR; R-type(00h)->EXEC_R; addi/addiu(08h/09h), andi(0Ch), ori(0Dh), slti(0Ah), lui(0Fh)->EXEC_I; beq(04h)/bne(05h)->BRANCH; j(02h)->JUMP; any other->see Optional Feature.
- MEMADR: AluSrcA=1, AluSrcB=2, ExtOp=1, Aluctrl=ADD.
  - Next state: MEMRD if lw, MEMWR if sw.
- MEMRD: MemR=1, IorD=1. Next state: MEMWB.
- MEMWB: RegW=1, RegDst=0, Mem2R=1. Next state: FETCH.
- MEMWR: MemW=1, IorD=1. Next state: FETCH.
- EXEC_R: AluSrcA=1, AluSrcB=0.
  - Aluctrl from funct: 20h/21h ADD, 22h/23h SUB, 24h AND, 25h OR, 26h XOR, 27h NOR, 2Ah SLT, 00h SLL, 02h SRL.
  - An unknown funct is treated as an illegal instruction.
  - Next state: RWB.
- RWB: RegW=1, RegDst=1, Mem2R=0. Next state: FETCH.
- EXEC_I: AluSrcA=1, AluSrcB=2.
  - ExtOp=1 for addi/addiu/slti, 0 for andi/ori, 2 for lui.
  - Aluctrl: ADD / ADD / SLT / AND / OR / LUI respectively.
  - Next state: IWB.
- IWB: RegW=1, RegDst=0, Mem2R=0. Next state: FETCH.
- BRANCH: AluSrcA=1, AluSrcB=0, Aluctrl=SUB, PCSource=1.
  - PcEn = Zero for beq, ~Zero for bne (same cycle, combinational on Zero).
  - Next state: FETCH.
- JUMP: PCSource=2, PcEn=1. Next state: FETCH.
- InstrCnt increments by 1 on every transition into FETCH from a non-FETCH, non-TRAP state. It wraps modulo 2^CNT_W.
- Latency in cycles: lw 5; sw, R-type and I-ALU 4; beq/bne and j 3.
- Reset asserted mid-instruction: FETCH on the next edge, with no MemW or RegW issued in the reset cycle.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode/funct moves DECODE (or EXEC_R) -> TRAP.
  - TRAP asserts Illegal=1 with all enables 0, and is held until Reset.
  - InstrCnt is not incremented.
- Undefined: the illegal instruction behaves as a NOP.
  - Next state is FETCH, InstrCnt increments, Illegal is tied 0, and the TRAP state is unreachable.

Test Plan:
- Reset held 2 cycles, then released -> State=0, InstrCnt=0; FETCH shows MemR=1, IRWrite=1, PcEn=1, AluSrcB=1.
- lw (OpCode=23h) -> states 0,1,2,3,4,0; RegW=1 and Mem2R=1 only in state 4; InstrCnt=1.
- R-type subu (funct=23h) -> Aluctrl=1 in state 6, RegW=1 with RegDst=1 in state 7, 4 cycles total.
- beq with Zero=1 -> PcEn=1, PCSource=1 in state 10; bne with Zero=1 -> PcEn=0; each takes 3 cycles.
- ori (0Dh) then lui (0Fh) -> ExtOp=0 and Aluctrl=3, then ExtOp=2 and Aluctrl=9; InstrCnt goes 1 then 2.
- OpCode=3Fh -> with MC_CTRL_ILLEGAL_TRAP_EN: State=12, Illegal=1, held for 10 cycles until Reset; without it: back to FETCH and InstrCnt+1.
